// File: rtl/quadrature_gen.sv
`default_nettype none
// ============================================================================
// Module      : quadrature_gen
// Description : Quadrature step generator. Queues up/down step commands and
//               plays each one out as a two-phase x/y waveform (idle xy=11).
//               Define QGEN_INDEX_EN to add the z index output.
// Revision    : 1.0 - initial release
// ============================================================================
module quadrature_gen #(
   parameter int PHASE_CYCLES = 4,
   parameter int PEND_W       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic       cmd_dir,
   output logic       cmd_ready,
   output logic       x,
   output logic       y,
   output logic       busy,
   output logic [7:0] position
`ifdef QGEN_INDEX_EN
   ,
   output logic       z
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_P1   = 3'd1,
      ST_P2   = 3'd2,
      ST_P3   = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   localparam logic [7:0]        c_TIMER_LOAD = 8'(PHASE_CYCLES - 1);
   localparam logic [PEND_W-1:0] c_PEND_MAX   = '1;

   state_t            r_state, w_state_nxt;
   logic [7:0]        r_timer, w_timer_nxt;
   logic [PEND_W-1:0] r_pending;
   logic              r_pend_dir;
   logic              r_step_dir;
   logic [7:0]        r_position;
   logic              r_x, r_y;
   logic              w_accept, w_dequeue, w_pos_upd, w_expire, w_dir_nxt;
   logic [1:0]        w_xy_nxt;

   assign cmd_ready = (r_pending != c_PEND_MAX) &&
                      ((r_pending == '0) || (cmd_dir == r_pend_dir));
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_expire  = (r_timer == 8'd0);
   assign w_dir_nxt = w_dequeue ? r_pend_dir : r_step_dir;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_timer <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   // GAP expiring with work queued chains straight into P1 so back-to-back
   // steps repeat every 4*PHASE_CYCLES cycles with no extra idle cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer - 8'd1;
      w_dequeue   = 1'b0;
      w_pos_upd   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_timer_nxt = c_TIMER_LOAD;
            if (r_pending != '0) begin
               w_state_nxt = ST_P1;
               w_dequeue   = 1'b1;
            end
         end
         ST_P1: if (w_expire) begin
            w_state_nxt = ST_P2;
            w_timer_nxt = c_TIMER_LOAD;
         end
         ST_P2: if (w_expire) begin
            w_state_nxt = ST_P3;
            w_timer_nxt = c_TIMER_LOAD;
         end
         ST_P3: if (w_expire) begin
            w_state_nxt = ST_GAP;
            w_timer_nxt = c_TIMER_LOAD;
            w_pos_upd   = 1'b1;
         end
         ST_GAP: if (w_expire) begin
            w_timer_nxt = c_TIMER_LOAD;
            if (r_pending != '0) begin
               w_state_nxt = ST_P1;
               w_dequeue   = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = c_TIMER_LOAD;
         end
      endcase
   end

   always_comb begin
      w_xy_nxt = 2'b11;
      case (w_state_nxt)
         ST_P1:   w_xy_nxt = w_dir_nxt ? 2'b10 : 2'b01;
         ST_P2:   w_xy_nxt = 2'b00;
         ST_P3:   w_xy_nxt = w_dir_nxt ? 2'b01 : 2'b10;
         default: w_xy_nxt = 2'b11;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending  <= '0;
         r_pend_dir <= 1'b0;
         r_step_dir <= 1'b0;
         r_position <= 8'd0;
         r_x        <= 1'b1;
         r_y        <= 1'b1;
      end else begin
         if (w_accept && !w_dequeue)
            r_pending <= r_pending + PEND_W'(1);
         else if (!w_accept && w_dequeue)
            r_pending <= r_pending - PEND_W'(1);
         if (w_accept)
            r_pend_dir <= cmd_dir;
         r_step_dir <= w_dir_nxt;
         if (w_pos_upd)
            r_position <= r_step_dir ? r_position + 8'd1 : r_position - 8'd1;
         r_x <= w_xy_nxt[1];
         r_y <= w_xy_nxt[0];
      end
   end

`ifdef QGEN_INDEX_EN
   logic r_z;
   // Position is stable through P2, so the wrap test can use its current value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_z <= 1'b0;
      else
         r_z <= (w_state_nxt == ST_P2) &&
                (w_dir_nxt ? (r_position == 8'hFF) : (r_position == 8'h00));
   end
   assign z = r_z;
`endif

   assign x        = r_x;
   assign y        = r_y;
   assign busy     = (r_state != ST_IDLE) || (r_pending != '0);
   assign position = r_position;

endmodule
`default_nettype wire
